// File: rtl/s2p_pkg.sv
// Shared FSM state type for the serial-to-parallel converter.
package s2p_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } s2p_state_e;

endpackage

// File: rtl/serial_to_parallel.sv
// Assembles LSB-first serial bits into DATA_W-bit words; word valid 1 cycle after its last bit.
// Output register decouples assembly; a second completed word stalls s_ready_o until the output drains.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int COUNTLEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_i,
  input  logic              s_data_i,
  output logic              s_ready_o,
  output logic              p_valid_o,
  output logic [DATA_W-1:0] p_data_o,
  input  logic              p_ready_i
);

  s2p_state_e          state_q, state_d;
  logic [COUNTLEN-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                p_valid_q, p_valid_d;
  logic                s_xfer;
  logic                last_bit;

  assign s_xfer   = s_valid_i && (state_q == COLLECT);
  assign last_bit = (bit_cnt_q == COUNTLEN'(DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    asm_d     = asm_q;
    p_data_d  = p_data_q;
    // A parallel transfer empties the output unless a new word replaces it below.
    p_valid_d = p_valid_q && !p_ready_i;

    case (state_q)
      COLLECT: begin
        if (s_xfer) begin
          asm_d[bit_cnt_q] = s_data_i;
          if (last_bit) begin
            bit_cnt_d = '0;
            if (!p_valid_q || p_ready_i) begin
              p_data_d  = asm_d;
              p_valid_d = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        // p_valid_q is always set here, so p_ready_i alone means the output drains.
        if (p_ready_i) begin
          p_data_d  = asm_q;
          p_valid_d = 1'b1;
          state_d   = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      bit_cnt_q <= '0;
      asm_q     <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      asm_q     <= asm_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign s_ready_o = (state_q == COLLECT);
  assign p_valid_o = p_valid_q;
  assign p_data_o  = p_data_q;

endmodule
